// File: rtl/hsp_write_arbiter.sv
// rtl/hsp_write_arbiter.sv - round-robin arbiter sharing one HSP FIFO write port among lanes
// One filtered holding slot per lane feeds a single output register; a flush FSM drains both.
module hsp_write_arbiter #(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 8,
  parameter int MIN_SCORE = 0,
  parameter int CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_LANES-1:0]          lane_valid,
  output logic [NUM_LANES-1:0]          lane_ready,
  input  logic [NUM_LANES*DATA_W-1:0]   lane_s,
  input  logic [NUM_LANES*DATA_W-1:0]   lane_q,
  input  logic [NUM_LANES*DATA_W-1:0]   lane_l,
  input  logic [NUM_LANES*DATA_W-1:0]   lane_score,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_W-1:0]             fifo_s,
  output logic [DATA_W-1:0]             fifo_q,
  output logic [DATA_W-1:0]             fifo_l,
  output logic [DATA_W-1:0]             fifo_score,
  output logic [$clog2(NUM_LANES)-1:0]  grant_lane,
  input  logic                          flush_req,
  output logic                          flush_done,
  output logic [CNT_W-1:0]              hsp_count,
  output logic [CNT_W-1:0]              drop_count
);

  localparam int LW = $clog2(NUM_LANES);
  localparam logic [DATA_W:0] MIN_W = (DATA_W+1)'(MIN_SCORE);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic                  w_run, w_done;
  logic [NUM_LANES-1:0]  r_hold_valid;
  logic [DATA_W-1:0]     r_hold_s [NUM_LANES];
  logic [DATA_W-1:0]     r_hold_q [NUM_LANES];
  logic [DATA_W-1:0]     r_hold_l [NUM_LANES];
  logic [DATA_W-1:0]     r_hold_sc[NUM_LANES];
  logic                  r_out_valid;
  logic [DATA_W-1:0]     r_out_s, r_out_q, r_out_l, r_out_sc;
  logic [LW-1:0]         r_rr_ptr, r_grant;
  logic [CNT_W-1:0]      r_hsp_cnt, r_drop_cnt;
  logic [NUM_LANES-1:0]  w_accept, w_drop, w_keep;
  logic                  w_any, w_load;
  logic [LW-1:0]         w_gnt;
  logic [CNT_W:0]        w_drop_n, w_drop_sum;

  function automatic logic [LW-1:0] f_wrap(input logic [LW-1:0] p, input int k);
    int t;
    t = int'(p) + k;
    if (t >= NUM_LANES) t = t - NUM_LANES;
    return LW'(t);
  endfunction

  // A record is dropped when its length is zero or the score borrow shows score < MIN_SCORE
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [DATA_W-1:0] w_l, w_sc;
    logic [DATA_W:0]   w_diff;
    assign w_l         = lane_l[g*DATA_W +: DATA_W];
    assign w_sc        = lane_score[g*DATA_W +: DATA_W];
    assign w_diff      = {1'b0, w_sc} - MIN_W;
    assign w_accept[g] = lane_valid[g] & lane_ready[g];
    assign w_drop[g]   = w_accept[g] & ((w_l == '0) | w_diff[DATA_W]);
    assign w_keep[g]   = w_accept[g] & ~w_drop[g];
  end

  assign lane_ready = ~r_hold_valid & {NUM_LANES{w_run & rst_n}};
  assign fifo_wr_en = r_out_valid & ~fifo_full;
  assign w_load     = (~r_out_valid | fifo_wr_en) & w_any;

  // Descending scan so the last hit is the first set slot after rr_ptr
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    for (int k = NUM_LANES; k >= 1; k--) begin
      if (r_hold_valid[f_wrap(r_rr_ptr, k)]) begin
        w_any = 1'b1;
        w_gnt = f_wrap(r_rr_ptr, k);
      end
    end
  end

  always_comb begin
    w_drop_n = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_drop_n = w_drop_n + (CNT_W+1)'(w_drop[i]);
    end
    w_drop_sum = {1'b0, r_drop_cnt} + w_drop_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (w_load && (w_gnt == LW'(i))) r_hold_valid[i] <= 1'b0;
        if (w_keep[i])                   r_hold_valid[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (w_keep[i]) begin
        r_hold_s[i]  <= lane_s[i*DATA_W +: DATA_W];
        r_hold_q[i]  <= lane_q[i*DATA_W +: DATA_W];
        r_hold_l[i]  <= lane_l[i*DATA_W +: DATA_W];
        r_hold_sc[i] <= lane_score[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_s     <= '0;
      r_out_q     <= '0;
      r_out_l     <= '0;
      r_out_sc    <= '0;
      r_rr_ptr    <= LW'(NUM_LANES - 1);
      r_grant     <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_s     <= r_hold_s[w_gnt];
      r_out_q     <= r_hold_q[w_gnt];
      r_out_l     <= r_hold_l[w_gnt];
      r_out_sc    <= r_hold_sc[w_gnt];
      r_rr_ptr    <= w_gnt;
      r_grant     <= w_gnt;
    end else if (fifo_wr_en) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsp_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (fifo_wr_en && (r_hsp_cnt != '1)) r_hsp_cnt <= r_hsp_cnt + CNT_W'(1);
      r_drop_cnt <= w_drop_sum[CNT_W] ? '1 : w_drop_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_RUN: begin
        w_run = 1'b1;
        if (flush_req) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!(|r_hold_valid) && !r_out_valid) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  assign fifo_s     = r_out_s;
  assign fifo_q     = r_out_q;
  assign fifo_l     = r_out_l;
  assign fifo_score = r_out_sc;
  assign grant_lane = r_grant;
  assign flush_done = w_done;
  assign hsp_count  = r_hsp_cnt;
  assign drop_count = r_drop_cnt;

endmodule
